// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the 64x64 memristor array sequencer.
package mc_ctrl_pkg;

  localparam int ROWS  = 64;
  localparam int COLS  = 64;
  localparam int ROW_W = 6;

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE_A, GAP, PULSE_B, ARM, EVAL, RESP
  } state_e;

  typedef enum logic {OP_RD, OP_WR} op_e;

  // Down-counter reload for a program pulse; a zero length still gives one cycle.
  function automatic logic [7:0] pulse_m1(input logic [7:0] cfg);
    return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
  endfunction

endpackage

// File: rtl/mc_row_decoder.sv
// Row address to one-hot word-line decode; even rows sit on CWLO, odd rows on CWLE.
module mc_row_decoder #(
  parameter int ROWS = 64
) (
  input  logic [5:0]        row_i,
  input  logic              wl_en_i,
  output logic [ROWS/2-1:0] cwle_o,
  output logic [ROWS/2-1:0] cwlo_o
);

  always_comb begin
    cwle_o = '0;
    cwlo_o = '0;
    if (wl_en_i) begin
      if (row_i[0]) cwle_o[row_i[5:1]] = 1'b1;
      else          cwlo_o[row_i[5:1]] = 1'b1;
    end
  end

endmodule

// File: rtl/mc_array_ctrl.sv
// Row write/read sequencer for the memristor array; every array pin is a flop
// loaded from the next-state decode so pins line up exactly with state_q.
module mc_array_ctrl #(
  parameter int ROWS     = 64,
  parameter int COLS     = 64,
  parameter int ARM_CYC  = 2,
  parameter int EVAL_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [5:0]        req_row_i,
  input  logic [COLS-1:0]   req_wdata_i,
  input  logic [COLS-1:0]   req_mask_i,
  input  logic [7:0]        cfg_pulse_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [COLS-1:0]   rsp_rdata_o,
  output logic              wr_done_o,
  output logic              busy_o,
  output logic [ROWS/2-1:0] CWLE_o,
  output logic [ROWS/2-1:0] CWLO_o,
  output logic [COLS-1:0]   CBL_o,
  output logic [COLS-1:0]   CBLEN_o,
  output logic [COLS-1:0]   CSL_o,
  output logic [COLS-1:0]   DIN_o,
  output logic [COLS-1:0]   DINb_o,
  input  logic [COLS-1:0]   DOUT_i
);
  import mc_ctrl_pkg::*;

  localparam logic [7:0] ARM_M1  = 8'(ARM_CYC - 1);
  localparam logic [7:0] EVAL_M1 = 8'(EVAL_CYC - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [7:0]        cnt_q, cnt_d, pm1_q, pm1_d;
  logic [5:0]        row_q, row_d;
  logic [COLS-1:0]   wdata_q, wdata_d, mask_q, mask_d, rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d, wr_done_q, wr_done_d;
  logic [ROWS/2-1:0] cwle_q, cwle_d, cwlo_q, cwlo_d;
  logic [COLS-1:0]   cbl_q, cbl_d, cblen_q, cblen_d, csl_q, csl_d;
  logic [COLS-1:0]   din_q, din_d, dinb_q, dinb_d;
  logic              wl_en;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    pm1_d       = pm1_q;
    row_d       = row_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        op_d    = req_we_i ? OP_WR : OP_RD;
        row_d   = req_row_i;
        wdata_d = req_wdata_i;
        mask_d  = req_mask_i;
        pm1_d   = pulse_m1(cfg_pulse_i);
        state_d = SETUP;
      end
      SETUP: begin
        state_d = (op_q == OP_WR) ? PULSE_A : ARM;
        cnt_d   = (op_q == OP_WR) ? pm1_q : ARM_M1;
      end
      PULSE_A: begin
        if (cnt_q == 8'd0) state_d = GAP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      GAP: begin
        state_d = PULSE_B;
        cnt_d   = pm1_q;
      end
      PULSE_B: begin
        if (cnt_q == 8'd0) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else cnt_d = cnt_q - 8'd1;
      end
      ARM: begin
        if (cnt_q == 8'd0) begin
          state_d = EVAL;
          cnt_d   = EVAL_M1;
        end else cnt_d = cnt_q - 8'd1;
      end
      EVAL: begin
        // Pins still hold the eval drive on this edge; the cell returns ~m0.
        if (cnt_q == 8'd0) begin
          state_d     = RESP;
          rdata_d     = ~DOUT_i;
          rsp_valid_d = 1'b1;
        end else cnt_d = cnt_q - 8'd1;
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wl_en   = (state_d == PULSE_A) || (state_d == PULSE_B) ||
              (state_d == ARM)     || (state_d == EVAL);
    cbl_d   = '0;
    cblen_d = '0;
    csl_d   = '0;
    din_d   = '0;
    dinb_d  = '0;
    case (state_d)
      SETUP: begin
        if (op_d == OP_WR) begin
          cbl_d = ~wdata_d;
          csl_d = wdata_d;
        end else din_d = '1;
      end
      PULSE_A: begin
        cbl_d   = ~wdata_d;
        csl_d   = wdata_d;
        cblen_d = mask_d;
      end
      GAP: begin
        cbl_d = ~wdata_d;
        csl_d = ~wdata_d;
      end
      PULSE_B: begin
        cbl_d   = ~wdata_d;
        csl_d   = ~wdata_d;
        cblen_d = mask_d;
      end
      ARM: begin
        din_d = '1;
        csl_d = '1;
      end
      EVAL: din_d = '1;
      default: ;
    endcase
  end

  mc_row_decoder #(.ROWS(ROWS)) u_row_dec (
    .row_i   (row_d),
    .wl_en_i (wl_en),
    .cwle_o  (cwle_d),
    .cwlo_o  (cwlo_d)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      cnt_q       <= '0;
      pm1_q       <= '0;
      row_q       <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      cwle_q      <= '0;
      cwlo_q      <= '0;
      cbl_q       <= '0;
      cblen_q     <= '0;
      csl_q       <= '0;
      din_q       <= '0;
      dinb_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      pm1_q       <= pm1_d;
      row_q       <= row_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      cwle_q      <= cwle_d;
      cwlo_q      <= cwlo_d;
      cbl_q       <= cbl_d;
      cblen_q     <= cblen_d;
      csl_q       <= csl_d;
      din_q       <= din_d;
      dinb_q      <= dinb_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign wr_done_o   = wr_done_q;
  assign CWLE_o      = cwle_q;
  assign CWLO_o      = cwlo_q;
  assign CBL_o       = cbl_q;
  assign CBLEN_o     = cblen_q;
  assign CSL_o       = csl_q;
  assign DIN_o       = din_q;
  assign DINb_o      = dinb_q;

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Directed bench for mc_array_ctrl with a behavioural complementary-pair cell array.
module tb_mc_array_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [5:0]  req_row_i = '0;
  logic [63:0] req_wdata_i = '0, req_mask_i = '0;
  logic [7:0]  cfg_pulse_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [63:0] rsp_rdata_o;
  logic        wr_done_o, busy_o;
  logic [31:0] CWLE_o, CWLO_o;
  logic [63:0] CBL_o, CBLEN_o, CSL_o, DIN_o, DINb_o, DOUT_i;

  int total = 0, bad = 0, viol = 0;
  logic [63:0] m0 [64];
  logic [63:0] m1 [64];

  localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  always #5 clk_i = ~clk_i;

  mc_array_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_row_i(req_row_i), .req_wdata_i(req_wdata_i), .req_mask_i(req_mask_i),
    .cfg_pulse_i(cfg_pulse_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .wr_done_o(wr_done_o), .busy_o(busy_o),
    .CWLE_o(CWLE_o), .CWLO_o(CWLO_o), .CBL_o(CBL_o), .CBLEN_o(CBLEN_o),
    .CSL_o(CSL_o), .DIN_o(DIN_o), .DINb_o(DINb_o), .DOUT_i(DOUT_i)
  );

  initial begin
    for (int r = 0; r < 64; r++) begin
      m0[r] = '0;
      m1[r] = '1;
    end
  end

  // Cell array: a selected, enabled pair with CBL != CSL programs m0 to CSL, else m1 to CBL.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int r = 0; r < 64; r++) begin
        if (((r % 2) == 1) ? CWLE_o[r/2] : CWLO_o[r/2]) begin
          for (int c = 0; c < 64; c++) begin
            if (CBLEN_o[c]) begin
              if (CBL_o[c] != CSL_o[c]) m0[r][c] <= CSL_o[c];
              else                      m1[r][c] <= CBL_o[c];
            end
          end
        end
      end
      if ($countones({CWLE_o, CWLO_o}) > 1) viol++;
      if ((DIN_o != '0) && (CBLEN_o != '0)) viol++;
    end
  end

  always_comb begin
    DOUT_i = '0;
    for (int r = 0; r < 64; r++)
      if (((r % 2) == 1) ? CWLE_o[r/2] : CWLO_o[r/2])
        DOUT_i = DOUT_i | (~m0[r] & DIN_o & ~DINb_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue a write; cycle 1 is the first negedge after the accept edge.
  task automatic do_write(input logic [5:0] row, input logic [63:0] d, input logic [63:0] m,
                          input logic [7:0] cfg, output int done_cyc, output int wl_cyc,
                          output logic [31:0] wl_hist, output int other);
    int k;
    logic sel;
    @(negedge clk_i);
    req_we_i = 1'b1; req_row_i = row; req_wdata_i = d; req_mask_i = m;
    cfg_pulse_i = cfg; req_valid_i = 1'b1;
    k = 0;
    while (!req_ready_o && k < 600) begin @(negedge clk_i); k++; end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    done_cyc = -1; wl_cyc = 0; wl_hist = '0; other = 0;
    for (int c = 1; c <= 600; c++) begin
      sel = row[0] ? CWLE_o[row[5:1]] : CWLO_o[row[5:1]];
      if (sel) begin
        wl_cyc++;
        if (c < 32) wl_hist[c] = 1'b1;
      end
      other += $countones({CWLE_o, CWLO_o}) - int'(sel);
      if (wr_done_o) begin
        done_cyc = c;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic do_read(input logic [5:0] row, input int hold, output logic [63:0] data,
                         output int vcyc, output logic [31:0] csl_hist);
    int k;
    @(negedge clk_i);
    req_we_i = 1'b0; req_row_i = row; req_valid_i = 1'b1;
    k = 0;
    while (!req_ready_o && k < 600) begin @(negedge clk_i); k++; end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    vcyc = -1; csl_hist = '0;
    for (int c = 1; c <= 100; c++) begin
      if (CSL_o == '1 && c < 32) csl_hist[c] = 1'b1;
      if (rsp_valid_o) begin
        vcyc = c;
        break;
      end
      @(negedge clk_i);
    end
    data = rsp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("rsp_hold_data", rsp_rdata_o, data);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_after_hs", 64'(rsp_valid_o), 64'd0);
    chk("ready_after_rd", 64'(req_ready_o), 64'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wl"}, {CWLE_o, CWLO_o}, 64'd0);
    chk({tag, "_col"}, CBL_o | CBLEN_o | CSL_o | DIN_o | DINb_o, 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_rsp"}, 64'({rsp_valid_o, wr_done_o}), 64'd0);
  endtask

  initial begin
    int dc, wc, oth, vc, k;
    logic [31:0] hist;
    logic [63:0] rd;

    repeat (3) @(negedge clk_i);
    chk_quiet("reset");
    rst_ni = 1'b1;

    // Full write row 5, P=3: word line on cycles 2-4 and 6-8, done at cycle 9.
    do_write(6'd5, PAT_A5, '1, 8'd3, dc, wc, hist, oth);
    chk("wr5_done_cyc", 64'(dc), 64'd9);
    chk("wr5_wl_hist", 64'(hist), 64'h1DC);
    chk("wr5_wl_cyc", 64'(wc), 64'd6);
    chk("wr5_other_wl", 64'(oth), 64'd0);
    chk("wr5_cell_m0", m0[5], PAT_A5);
    chk("wr5_cell_m1", m1[5], ~PAT_A5);

    do_read(6'd5, 4, rd, vc, hist);
    chk("rd5_data", rd, PAT_A5);
    chk("rd5_valid_cyc", 64'(vc), 64'd6);
    chk("rd5_csl_hist", 64'(hist), 64'hC);

    // Masked write touches only columns 0-3.
    do_write(6'd0, 64'h0123_4567_89AB_CDEF, '1, 8'd2, dc, wc, hist, oth);
    chk("wr0_done_cyc", 64'(dc), 64'd7);
    do_write(6'd0, 64'h0, 64'hF, 8'd1, dc, wc, hist, oth);
    chk("wr0m_done_cyc", 64'(dc), 64'd5);
    do_read(6'd0, 0, rd, vc, hist);
    chk("rd0_masked", rd, 64'h0123_4567_89AB_CDE0);

    // Zero mask runs the full timing and leaves the row alone.
    do_write(6'd5, 64'h0, 64'h0, 8'd2, dc, wc, hist, oth);
    chk("wrz_done_cyc", 64'(dc), 64'd7);
    chk("wrz_wl_cyc", 64'(wc), 64'd4);
    do_read(6'd5, 0, rd, vc, hist);
    chk("rdz_data", rd, PAT_A5);

    // Pulse length extremes.
    do_write(6'd9, 64'hDEAD_BEEF_0BAD_F00D, '1, 8'd0, dc, wc, hist, oth);
    chk("p0_done_cyc", 64'(dc), 64'd5);
    chk("p0_wl_hist", 64'(hist), 64'h14);
    do_write(6'd9, 64'h2152_4110_F452_0FF2, '1, 8'd255, dc, wc, hist, oth);
    chk("p255_done_cyc", 64'(dc), 64'd513);
    chk("p255_wl_cyc", 64'(wc), 64'd510);
    chk("p255_other_wl", 64'(oth), 64'd0);
    do_read(6'd9, 0, rd, vc, hist);
    chk("rd9_data", rd, 64'h2152_4110_F452_0FF2);

    // Back-to-back: a read waiting during a P=1 write is taken on the first idle cycle.
    @(negedge clk_i);
    req_we_i = 1'b1; req_row_i = 6'd7; req_wdata_i = 64'h55; req_mask_i = '1;
    cfg_pulse_i = 8'd1; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_we_i = 1'b0; req_row_i = 6'd5;
    chk("b2b_ready_busy", 64'(req_ready_o), 64'd0);
    k = -1;
    for (int c = 1; c <= 20; c++) begin
      if (req_ready_o) begin
        k = c;
        break;
      end
      @(negedge clk_i);
    end
    chk("b2b_accept_cyc", 64'(k), 64'd5);
    chk("b2b_wr_done", 64'(wr_done_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("b2b_rd_busy", 64'(busy_o), 64'd1);
    k = 0;
    while (!rsp_valid_o && k < 50) begin @(negedge clk_i); k++; end
    chk("b2b_rd_wait", 64'(k), 64'd5);
    chk("b2b_rd_data", rsp_rdata_o, PAT_A5);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("b2b_row7_m0", m0[7], 64'h55);

    // Reset in the middle of PULSE_A drops every array pin on the first reset edge.
    @(negedge clk_i);
    req_we_i = 1'b1; req_row_i = 6'd9; req_wdata_i = 64'h1; req_mask_i = '1;
    cfg_pulse_i = 8'd10; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_wl", 64'(CWLE_o[4]), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk_quiet("midrst");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    do_read(6'd5, 0, rd, vc, hist);
    chk("post_rst_rd", rd, PAT_A5);

    chk("invariants", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
